// File: rtl/pol_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pol_sync_pkg
//  Description : Shared definitions for the polarity-programmable input
//                conditioner: counter-width derivation, parameter legality
//                and the edge classification type used by each channel.
//  Revision    : 1.0  initial release
// ============================================================================
package pol_sync_pkg;

  // Smallest legal values for the conditioner parameters.
  localparam int c_MIN_WIDTH       = 1;
  localparam int c_MIN_SYNC_STAGES = 2;
  localparam int c_MIN_FILT_CYCLES = 1;

  // Result of one filter evaluation for a single channel.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = (value > 0) ? value - 1 : 0;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // Persistence counter width: must hold 0..FILT_CYCLES-1, never narrower
  // than one bit so FILT_CYCLES=1 still has a real (constant-zero) register.
  function automatic int cnt_width(input int filt_cycles);
    int bits;
    bits = clog2(filt_cycles);
    return (bits < 1) ? 1 : bits;
  endfunction

  // True when every parameter is within its legal range.
  function automatic bit params_legal(input int width,
                                      input int sync_stages,
                                      input int filt_cycles);
    return (width >= c_MIN_WIDTH) &&
           (sync_stages >= c_MIN_SYNC_STAGES) &&
           (filt_cycles >= c_MIN_FILT_CYCLES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pol_filt_chan.sv
`default_nettype none
// ============================================================================
//  Module      : pol_filt_chan
//  Description : One conditioner channel: synchroniser chain, polarity XOR,
//                persistence counter and registered rise/fall pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module pol_filt_chan
  import pol_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_a,
  input  logic i_inv,
  input  logic i_en,
  output logic o_q,
  output logic o_qr,
  output logic o_qf
);

  localparam int               CNT_W  = cnt_width(FILT_CYCLES);
  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_q;
  logic                   r_qr;
  logic                   r_qf;

  logic  w_s;
  logic  w_p;
  logic  w_differs;
  logic  w_term;
  edge_e w_edge;

  // Synchronised level, polarity-corrected, compared with the held output.
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_p       = w_s ^ i_inv;
  assign w_differs = w_p ^ r_q;
  assign w_term    = (r_cnt == c_TERM);

  // Shift the raw input through the synchroniser; runs regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_a};
    end
  end

  // Decide whether this edge commits a new level, and in which direction.
  always_comb begin
    w_edge = EDGE_NONE;
    if (i_en && w_differs && w_term) begin
      w_edge = w_p ? EDGE_RISE : EDGE_FALL;
    end
  end

  // Persistence counter, held level and one-cycle edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
      r_qr  <= 1'b0;
      r_qf  <= 1'b0;
    end else begin
      r_qr <= (w_edge == EDGE_RISE);
      r_qf <= (w_edge == EDGE_FALL);
      if (w_edge != EDGE_NONE) begin
        r_q   <= w_p;
        r_cnt <= '0;
      end else if (!i_en || !w_differs) begin
        // Disabled, or the level fell back to Q: any partial count is a glitch.
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_q  = r_q;
  assign o_qr = r_qr;
  assign o_qf = r_qf;

endmodule
`default_nettype wire

// File: rtl/pol_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : pol_sync_filter
//  Description : WIDTH-channel synchronising, polarity-selectable debounce
//                filter producing a stable level plus rise/fall pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module pol_sync_filter
  import pol_sync_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] INV,
  input  logic             EN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QR,
  output logic [WIDTH-1:0] QF
);

  // Refuse to elaborate with out-of-range parameters.
  if (!params_legal(WIDTH, SYNC_STAGES, FILT_CYCLES)) begin : g_bad_params
    $error("pol_sync_filter: illegal parameters WIDTH=%0d SYNC_STAGES=%0d FILT_CYCLES=%0d",
           WIDTH, SYNC_STAGES, FILT_CYCLES);
  end

  // Channels are fully independent; each gets its own filter instance.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    pol_filt_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_chan (
      .clk   (CLK),
      .rst_n (RN),
      .i_a   (A[gi]),
      .i_inv (INV[gi]),
      .i_en  (EN),
      .o_q   (Q[gi]),
      .o_qr  (QR[gi]),
      .o_qf  (QF[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pol_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pol_sync_filter
//  Description : Directed self-checking bench for pol_sync_filter, default
//                instance plus a WIDTH=8 / SYNC_STAGES=3 / FILT_CYCLES=1 one.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pol_sync_filter;

  logic       clk;
  logic       rn;
  logic [3:0] a, inv;
  logic       en;
  logic [3:0] q, qr, qf;

  logic [7:0] a8, inv8;
  logic       en8;
  logic [7:0] q8, qr8, qf8;

  int n_checks;
  int n_pass;

  pol_sync_filter #(.WIDTH(4), .SYNC_STAGES(2), .FILT_CYCLES(4)) u_dut (
    .CLK (clk), .RN (rn), .A (a), .INV (inv), .EN (en),
    .Q (q), .QR (qr), .QF (qf)
  );

  pol_sync_filter #(.WIDTH(8), .SYNC_STAGES(3), .FILT_CYCLES(1)) u_sw (
    .CLK (clk), .RN (rn), .A (a8), .INV (inv8), .EN (en8),
    .Q (q8), .QR (qr8), .QF (qf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs set here are first
  // sampled by the following edge.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] exp4;
    logic [23:0] exp8;
    rn = 1'b0; a = '0; inv = '0; en = 1'b1;
    a8 = '0; inv8 = '0; en8 = 1'b1;
    #3;
    exp4 = '0; exp8 = '0;
    n_checks++;
    if ({q, qr, qf} !== exp4)
      $display("FAIL reset_dut: got %b expected %b", {q, qr, qf}, exp4);
    else n_pass++;
    n_checks++;
    if ({q8, qr8, qf8} !== exp8)
      $display("FAIL reset_sweep: got %h expected %h", {q8, qr8, qf8}, exp8);
    else n_pass++;
    next_edge();
    next_edge();
    rn = 1'b1;
    for (int e = 0; e < 6; e++) begin
      next_edge();
      n_checks++;
      if ({q, qr, qf} !== exp4)
        $display("FAIL idle_after_reset e=%0d: got %b expected %b", e, {q, qr, qf}, exp4);
      else n_pass++;
    end
  endtask

  task automatic test_step();
    logic [11:0] exp;
    a = 4'b0001;
    for (int e = 0; e < 8; e++) begin
      next_edge();
      exp = {(e >= 5) ? 4'b0001 : 4'b0000, (e == 5) ? 4'b0001 : 4'b0000, 4'b0000};
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL step_rise e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
    a = 4'b0000;
    for (int e = 0; e < 8; e++) begin
      next_edge();
      exp = {(e >= 5) ? 4'b0000 : 4'b0001, 4'b0000, (e == 5) ? 4'b0001 : 4'b0000};
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL step_fall e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic [11:0] exp;
    // Three sampled cycles high: rejected.
    a = 4'b0010;
    for (int e = 0; e < 12; e++) begin
      next_edge();
      if (e == 2) a = 4'b0000;
      exp = '0;
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL glitch3 e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
    // Four sampled cycles high: passes, then the fall passes too.
    a = 4'b0010;
    for (int e = 0; e < 13; e++) begin
      next_edge();
      if (e == 3) a = 4'b0000;
      exp = {(e >= 5 && e <= 8) ? 4'b0010 : 4'b0000,
             (e == 5) ? 4'b0010 : 4'b0000,
             (e == 9) ? 4'b0010 : 4'b0000};
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL glitch4 e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_polarity();
    logic [11:0] exp;
    inv = 4'b0100;
    for (int e = 0; e < 6; e++) begin
      next_edge();
      exp = {(e >= 3) ? 4'b0100 : 4'b0000, (e == 3) ? 4'b0100 : 4'b0000, 4'b0000};
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL inv_set e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
    inv = 4'b0000;
    for (int e = 0; e < 6; e++) begin
      next_edge();
      exp = {(e >= 3) ? 4'b0000 : 4'b0100, 4'b0000, (e == 3) ? 4'b0100 : 4'b0000};
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL inv_clr e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    logic [11:0] exp;
    en = 1'b0;
    a  = 4'b1000;
    for (int e = 0; e < 10; e++) begin
      next_edge();
      exp = '0;
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL en_low_hold e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
    en = 1'b1;
    for (int e = 0; e < 6; e++) begin
      next_edge();
      exp = {(e >= 3) ? 4'b1000 : 4'b0000, (e == 3) ? 4'b1000 : 4'b0000, 4'b0000};
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL en_rise e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    a = 4'b1001;
    for (int e = 0; e < 4; e++) begin
      next_edge();
      exp = {4'b1000, 4'b0000, 4'b0000};
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL mid_precount e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
    // Channel 0 has counted to 2 here; reset lands between clock edges.
    rn = 1'b0;
    #1;
    exp = '0;
    n_checks++;
    if ({q, qr, qf} !== exp)
      $display("FAIL mid_async_reset: got q/qr/qf=%b expected %b", {q, qr, qf}, exp);
    else n_pass++;
    next_edge();
    next_edge();
    n_checks++;
    if ({q, qr, qf} !== exp)
      $display("FAIL mid_reset_held: got q/qr/qf=%b expected %b", {q, qr, qf}, exp);
    else n_pass++;
    rn = 1'b1;
    for (int e = 0; e < 8; e++) begin
      next_edge();
      exp = {(e >= 5) ? 4'b1001 : 4'b0000, (e == 5) ? 4'b1001 : 4'b0000, 4'b0000};
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL post_reset_rise e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
    a = 4'b0000;
    for (int e = 0; e < 8; e++) begin
      next_edge();
      exp = {(e >= 5) ? 4'b0000 : 4'b1001, 4'b0000, (e == 5) ? 4'b1001 : 4'b0000};
      n_checks++;
      if ({q, qr, qf} !== exp)
        $display("FAIL post_reset_fall e=%0d: got q/qr/qf=%b expected %b", e, {q, qr, qf}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    logic [23:0] exp;
    // All eight channels step together.
    a8 = 8'hFF;
    for (int e = 0; e < 6; e++) begin
      next_edge();
      exp = {(e >= 3) ? 8'hFF : 8'h00, (e == 3) ? 8'hFF : 8'h00, 8'h00};
      n_checks++;
      if ({q8, qr8, qf8} !== exp)
        $display("FAIL sweep_step e=%0d: got q/qr/qf=%h expected %h", e, {q8, qr8, qf8}, exp);
      else n_pass++;
    end
    // A single-cycle low pulse propagates when FILT_CYCLES=1.
    a8 = 8'h00;
    for (int e = 0; e < 6; e++) begin
      next_edge();
      if (e == 0) a8 = 8'hFF;
      exp = {(e == 3) ? 8'h00 : 8'hFF, (e == 4) ? 8'hFF : 8'h00, (e == 3) ? 8'hFF : 8'h00};
      n_checks++;
      if ({q8, qr8, qf8} !== exp)
        $display("FAIL sweep_pulse e=%0d: got q/qr/qf=%h expected %h", e, {q8, qr8, qf8}, exp);
      else n_pass++;
    end
    // Polarity change on the low nibble responds at the first edge.
    inv8 = 8'h0F;
    for (int e = 0; e < 3; e++) begin
      next_edge();
      exp = {8'hF0, 8'h00, (e == 0) ? 8'h0F : 8'h00};
      n_checks++;
      if ({q8, qr8, qf8} !== exp)
        $display("FAIL sweep_inv_set e=%0d: got q/qr/qf=%h expected %h", e, {q8, qr8, qf8}, exp);
      else n_pass++;
    end
    inv8 = 8'h00;
    for (int e = 0; e < 3; e++) begin
      next_edge();
      exp = {8'hFF, (e == 0) ? 8'h0F : 8'h00, 8'h00};
      n_checks++;
      if ({q8, qr8, qf8} !== exp)
        $display("FAIL sweep_inv_clr e=%0d: got q/qr/qf=%h expected %h", e, {q8, qr8, qf8}, exp);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_step();
    test_glitch();
    test_polarity();
    test_enable();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
